// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// The master side is the producer/consumer environment; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cdb_valid;
  logic [TAG_WIDTH-1:0]          cdb_tag;
  logic [DATA_WIDTH-1:0]         cdb_data;
  logic [SRC_W-1:0]              cdb_src;
  logic [NUM_REQ-1:0]            pending;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, round-robin
// grant of one buffered result per cycle onto a registered broadcast bus.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  cdb_arbiter_if.slave   bus
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    held_q, held_d;
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_REQ];
  logic [TAG_WIDTH-1:0]  tag_d  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_d [NUM_REQ];
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]      cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0]    grant, ready, xfer;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  int unsigned           idx;

  // Rotating search starting one past the previous winner; first held slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (!flush) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (32'(last_grant_q) + k) % NUM_REQ;
        if (!grant_any && held_q[idx]) begin
          grant_any      = 1'b1;
          grant[idx]     = 1'b1;
          grant_idx      = SRC_W'(idx);
        end
      end
    end
  end

  // A draining slot is free to accept in the same cycle it is granted.
  assign ready = {NUM_REQ{rst_n & ~flush}} & (~held_q | grant);
  assign xfer  = bus.req_valid & ready;

  always_comb begin
    held_d = held_q & ~grant;
    tag_d  = tag_q;
    data_d = data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (xfer[i]) begin
        held_d[i] = 1'b1;
        tag_d[i]  = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_d[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (flush) begin
      held_d = '0;
    end

    cdb_valid_d  = grant_any;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (grant_any) begin
      cdb_tag_d    = tag_q[grant_idx];
      cdb_data_d   = data_q[grant_idx];
      cdb_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q       <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
    end else begin
      held_q       <= held_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Slot payload is only observed while held, so it carries no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.pending   = held_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized run
// compared against a slot-level behavioural model.
module tb_cdb_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  cdb_arbiter_if #(.NUM_REQ(4), .TAG_WIDTH(4), .DATA_WIDTH(32)) bus ();

  cdb_arbiter #(.NUM_REQ(4), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: slots, last winner and the broadcast register.
  bit          m_held  [N];
  logic [3:0]  m_tag   [N];
  logic [31:0] m_data  [N];
  int          m_last;
  bit          m_cv;
  logic [3:0]  m_ctag;
  logic [31:0] m_cdata;
  int          m_csrc;

  logic [3:0] obs_ready, exp_ready;

  function automatic int m_pick();
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      int d = (i - m_last - 1 + 2 * N) % N;
      if (m_held[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r = '0;
    int w = m_pick();
    if (rst_n && !flush)
      for (int i = 0; i < N; i++) r[i] = !m_held[i] || (i == w);
    return r;
  endfunction

  function automatic logic [3:0] m_pending();
    logic [3:0] p;
    for (int i = 0; i < N; i++) p[i] = m_held[i];
    return p;
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_held[i] = 0;
      m_cv = 0; m_ctag = '0; m_cdata = '0; m_csrc = 0; m_last = N - 1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_held[i] = 0;
      m_cv = 0;
    end else begin
      w = m_pick();
      if (w >= 0) begin
        m_cv = 1; m_ctag = m_tag[w]; m_cdata = m_data[w]; m_csrc = w;
        m_last = w; m_held[w] = 0;
      end else begin
        m_cv = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && !m_held[i]) begin
          m_held[i] = 1;
          m_tag[i]  = bus.req_tag[i*4 +: 4];
          m_data[i] = bus.req_data[i*32 +: 32];
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs_ready = bus.req_ready;
    exp_ready = m_ready();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input int u, input logic [3:0] t, input logic [31:0] d);
    bus.req_valid[u]        = 1'b1;
    bus.req_tag[u*4 +: 4]   = t;
    bus.req_data[u*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.req_valid = '0; bus.req_tag = '0; bus.req_data = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (obs_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0000", c, obs_ready);
      end
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, bus.pending} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got v=%b t=%h d=%h s=%0d p=%b expected all 0",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, bus.pending);
      end
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs_ready !== 4'b1111) begin
      n_fail++; $display("FAIL release_ready: got %b expected 1111", obs_ready);
    end
    set_req(2, 4'd5, 32'hDEADBEEF);
    tick();
    bus.req_valid = '0;
    n_tests++;
    if (bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lone_cycle1_valid: got %b expected 0", bus.cdb_valid);
    end
    tick();
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src} !== {1'b1, 4'd5, 32'hDEADBEEF, 2'd2}) begin
      n_fail++;
      $display("FAIL lone_broadcast: got v=%b t=%0d d=%h s=%0d expected v=1 t=5 d=deadbeef s=2",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src);
    end
    tick();
    n_tests++;
    if (bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lone_pulse_width: got %b expected 0", bus.cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] alt [4];
    alt[0] = 2'd1; alt[1] = 2'd3; alt[2] = 2'd1; alt[3] = 2'd3;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 32'h100 + 32'(i));
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag} !== {1'b1, 2'(k), 4'(k + 1)}) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got v=%b s=%0d t=%0d expected v=1 s=%0d t=%0d",
                 k, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, k, k + 1);
      end
    end
    set_req(1, 4'd6, 32'h201);
    set_req(3, 4'd8, 32'h203);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, alt[k]}) begin
        n_fail++;
        $display("FAIL rr_alternate[%0d]: got v=%b s=%0d expected v=1 s=%0d",
                 k, bus.cdb_valid, bus.cdb_src, alt[k]);
      end
    end
    bus.req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [3];
    seq[0] = 4'd7; seq[1] = 4'd8; seq[2] = 4'd9;
    bus.req_valid = '0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req(1, seq[k], 32'h700 + 32'(k));
      else bus.req_valid = '0;
      tick();
      if (k < 3) begin
        n_tests++;
        if (obs_ready[1] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, obs_ready[1]);
        end
      end
      if (k > 0) begin
        n_tests++;
        if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_src} !== {1'b1, seq[k-1], 2'd1}) begin
          n_fail++;
          $display("FAIL b2b_tag[%0d]: got v=%b t=%0d s=%0d expected v=1 t=%0d s=1",
                   k - 1, bus.cdb_valid, bus.cdb_tag, bus.cdb_src, seq[k-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit          outst [logic [31:0]];
    logic [31:0] cur [N];
    int          next_id = 1;
    logic [3:0]  v_s;
    do_reset();
    for (int i = 0; i < N; i++) begin
      cur[i] = 32'(next_id); next_id++;
      set_req(i, cur[i][3:0], cur[i]);
    end
    for (int c = 0; c < 50; c++) begin
      if (c == 40) bus.req_valid = '0;
      v_s = bus.req_valid;
      tick();
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready);
      end
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag} !== {m_cv, 2'(m_csrc), m_ctag}) begin
        n_fail++;
        $display("FAIL bp_cdb[%0d]: got v=%b s=%0d t=%0d expected v=%b s=%0d t=%0d",
                 c, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, m_cv, m_csrc, m_ctag);
      end
      if (bus.cdb_valid === 1'b1) begin
        n_tests++;
        if (!outst.exists(bus.cdb_data)) begin
          n_fail++;
          $display("FAIL bp_scoreboard[%0d]: got id %0d expected an outstanding id", c, bus.cdb_data);
        end else begin
          outst.delete(bus.cdb_data);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (v_s[i] && obs_ready[i]) begin
          outst[cur[i]] = 1'b1;
          cur[i] = 32'(next_id); next_id++;
          if (c < 39) set_req(i, cur[i][3:0], cur[i]);
        end
      end
    end
    n_tests++;
    if (outst.num() != 0) begin
      n_fail++; $display("FAIL bp_lost: got %0d undelivered expected 0", outst.num());
    end
  endtask

  task automatic test_flush();
    bit stale;
    do_reset();
    set_req(0, 4'd10, 32'hA0);
    set_req(1, 4'd11, 32'hA1);
    set_req(2, 4'd12, 32'hA2);
    tick();
    bus.req_valid = '0;
    tick();
    flush = 1'b1;
    set_req(3, 4'd13, 32'hA3);
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_tag} !== {1'b1, 4'd10}) begin
      n_fail++; $display("FAIL flush_prior_pulse: got v=%b t=%0d expected v=1 t=10", bus.cdb_valid, bus.cdb_tag);
    end
    tick();
    flush = 1'b0;
    bus.req_valid = '0;
    n_tests++;
    if (obs_ready !== 4'b0000) begin
      n_fail++; $display("FAIL flush_ready: got %b expected 0000", obs_ready);
    end
    n_tests++;
    if ({bus.cdb_valid, bus.pending} !== 5'b0) begin
      n_fail++; $display("FAIL flush_clear: got v=%b p=%b expected v=0 p=0000", bus.cdb_valid, bus.pending);
    end
    stale = 0;
    repeat (5) begin
      tick();
      if (bus.cdb_valid !== 1'b0) stale = 1;
    end
    n_tests++;
    if (stale) begin
      n_fail++; $display("FAIL flush_stale: got broadcast after flush expected none");
    end
    set_req(0, 4'd1, 32'hB0);
    set_req(1, 4'd2, 32'hB1);
    tick();
    bus.req_valid = '0;
    tick();
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL flush_keeps_last: got v=%b s=%0d expected v=1 s=1", bus.cdb_valid, bus.cdb_src);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 4'd3, 32'hC1);
    set_req(2, 4'd4, 32'hC2);
    set_req(3, 4'd5, 32'hC3);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (obs_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ready: got %b expected 0000", obs_ready);
    end
    n_tests++;
    if ({bus.cdb_valid, bus.pending} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b p=%b expected v=0 p=0000", bus.cdb_valid, bus.pending);
    end
    rst_n = 1'b1;
    set_req(2, 4'd6, 32'hD2);
    set_req(3, 4'd7, 32'hD3);
    tick();
    bus.req_valid = '0;
    tick();
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag} !== {1'b1, 2'd2, 4'd6}) begin
      n_fail++;
      $display("FAIL midrst_first_grant: got v=%b s=%0d t=%0d expected v=1 s=2 t=6",
               bus.cdb_valid, bus.cdb_src, bus.cdb_tag);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(63) != 0);
      flush = ($urandom_range(15) == 0);
      bus.req_valid = 4'($urandom);
      bus.req_tag   = 16'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n_tests++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready);
      end
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_data} !== {m_cv, 2'(m_csrc), m_ctag, m_cdata}) begin
        n_fail++;
        $display("FAIL rand_cdb[%0d]: got v=%b s=%0d t=%0d d=%h expected v=%b s=%0d t=%0d d=%h",
                 c, bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_data, m_cv, m_csrc, m_ctag, m_cdata);
      end
      n_tests++;
      if (bus.pending !== m_pending()) begin
        n_fail++; $display("FAIL rand_pending[%0d]: got %b expected %b", c, bus.pending, m_pending());
      end
    end
    rst_n = 1'b1; flush = 1'b0; bus.req_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_held[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_last = N - 1; m_cv = 0; m_ctag = '0; m_cdata = '0; m_csrc = 0;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
